// File: rtl/fifo_pkg.sv
// Shared types and helpers for the parametrised FIFO and its callers.
package fifo_pkg;

  // Pointer width: index bits plus one wrap bit.
  function automatic int ptr_w(input int depth);
    return $clog2(depth) + 1;
  endfunction

  typedef struct packed {
    logic full;
    logic almost_full;
    logic empty;
    logic almost_empty;
    logic overflow;
    logic underflow;
  } fifo_status_t;

endpackage

// File: rtl/fifo_ram.sv
// Simple dual-port storage: synchronous write, asynchronous read, no reset.
module fifo_ram #(
  parameter int DATA_WIDTH = 8,
  parameter int DEPTH      = 16
) (
  input  logic                       clk_i,
  input  logic                       we_i,
  input  logic [$clog2(DEPTH)-1:0]   waddr_i,
  input  logic [DATA_WIDTH-1:0]      wdata_i,
  input  logic [$clog2(DEPTH)-1:0]   raddr_i,
  output logic [DATA_WIDTH-1:0]      rdata_o
);

  logic [DATA_WIDTH-1:0] r_mem [DEPTH];

  always_ff @(posedge clk_i) begin
    if (we_i) begin
      r_mem[waddr_i] <= wdata_i;
    end
  end

  assign rdata_o = r_mem[raddr_i];

endmodule

// File: rtl/fifo_param.sv
// Parametrised first-word-fall-through FIFO with occupancy, threshold flags,
// flush and sticky error flags; all outputs decode registered state only.
module fifo_param
  import fifo_pkg::*;
#(
  parameter int DATA_WIDTH = 8,
  parameter int DEPTH      = 16,
  parameter int AF_THRESH  = DEPTH - 2,
  parameter int AE_THRESH  = 2
) (
  input  logic                     clk_i,
  input  logic                     rstn_i,
  input  logic                     flush_i,
  input  logic                     clr_err_i,
  input  logic [DATA_WIDTH-1:0]    data_i,
  input  logic                     push_i,
  output logic                     full_o,
  output logic                     almost_full_o,
  output logic [DATA_WIDTH-1:0]    data_o,
  input  logic                     pop_i,
  output logic                     empty_o,
  output logic                     almost_empty_o,
  output logic [$clog2(DEPTH):0]   count_o,
  output logic                     overflow_o,
  output logic                     underflow_o
);

  localparam int PW = ptr_w(DEPTH);
  localparam int AW = PW - 1;
  localparam logic [PW-1:0] DEPTH_C = PW'(DEPTH);
  localparam logic [PW-1:0] AF_C    = PW'(AF_THRESH);
  localparam logic [PW-1:0] AE_C    = PW'(AE_THRESH);

  logic [PW-1:0]         r_wptr;
  logic [PW-1:0]         r_rptr;
  logic                  r_ovf;
  logic                  r_udf;
  logic [PW-1:0]         w_count;
  logic                  w_push_acc;
  logic                  w_pop_acc;
  logic                  w_set_ovf;
  logic                  w_set_udf;
  logic [DATA_WIDTH-1:0] w_rdata;
  fifo_status_t          w_status;

  assign w_count = r_wptr - r_rptr;

  assign w_status.full         = (w_count == DEPTH_C);
  assign w_status.almost_full  = (w_count >= AF_C);
  assign w_status.empty        = (w_count == '0);
  assign w_status.almost_empty = (w_count <= AE_C);
  assign w_status.overflow     = r_ovf;
  assign w_status.underflow    = r_udf;

  // A push into a full FIFO is legal when the head leaves the same cycle.
  assign w_pop_acc  = ~flush_i & pop_i & ~w_status.empty;
  assign w_push_acc = ~flush_i & push_i & (~w_status.full | pop_i);
  assign w_set_ovf  = ~flush_i & push_i & w_status.full & ~pop_i;
  assign w_set_udf  = ~flush_i & pop_i & w_status.empty;

  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      r_wptr <= '0;
      r_rptr <= '0;
    end else if (flush_i) begin
      r_wptr <= '0;
      r_rptr <= '0;
    end else begin
      r_wptr <= r_wptr + PW'(w_push_acc);
      r_rptr <= r_rptr + PW'(w_pop_acc);
    end
  end

  // Set takes priority over clear so no error event is ever lost.
  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      r_ovf <= 1'b0;
      r_udf <= 1'b0;
    end else begin
      r_ovf <= w_set_ovf | (r_ovf & ~clr_err_i);
      r_udf <= w_set_udf | (r_udf & ~clr_err_i);
    end
  end

  fifo_ram #(
    .DATA_WIDTH (DATA_WIDTH),
    .DEPTH      (DEPTH)
  ) u_ram (
    .clk_i   (clk_i),
    .we_i    (w_push_acc),
    .waddr_i (r_wptr[AW-1:0]),
    .wdata_i (data_i),
    .raddr_i (r_rptr[AW-1:0]),
    .rdata_o (w_rdata)
  );

  assign data_o         = w_status.empty ? '0 : w_rdata;
  assign full_o         = w_status.full;
  assign almost_full_o  = w_status.almost_full;
  assign empty_o        = w_status.empty;
  assign almost_empty_o = w_status.almost_empty;
  assign overflow_o     = w_status.overflow;
  assign underflow_o    = w_status.underflow;
  assign count_o        = w_count;

endmodule

// File: tb/tb_fifo_param.sv
// Directed bench for fifo_param (DEPTH=4): status checked after each step,
// popped words checked by a scoreboard monitor on the falling edge.
module tb_fifo_param;

  logic       clk_i = 1'b0;
  logic       rstn_i = 1'b1;
  logic       flush_i = 1'b0;
  logic       clr_err_i = 1'b0;
  logic [7:0] data_i = '0;
  logic       push_i = 1'b0;
  logic       pop_i = 1'b0;
  logic       full_o, almost_full_o, empty_o, almost_empty_o;
  logic       overflow_o, underflow_o;
  logic [7:0] data_o;
  logic [2:0] count_o;

  int n_chk = 0;
  int n_fail = 0;
  logic [7:0] exp_q [$];

  fifo_param #(
    .DATA_WIDTH (8),
    .DEPTH      (4),
    .AF_THRESH  (3),
    .AE_THRESH  (1)
  ) dut (
    .clk_i          (clk_i),
    .rstn_i         (rstn_i),
    .flush_i        (flush_i),
    .clr_err_i      (clr_err_i),
    .data_i         (data_i),
    .push_i         (push_i),
    .full_o         (full_o),
    .almost_full_o  (almost_full_o),
    .data_o         (data_o),
    .pop_i          (pop_i),
    .empty_o        (empty_o),
    .almost_empty_o (almost_empty_o),
    .count_o        (count_o),
    .overflow_o     (overflow_o),
    .underflow_o    (underflow_o)
  );

  always #5 clk_i = ~clk_i;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Status vector: {count, full, almost_full, empty, almost_empty, overflow, underflow}
  task automatic chk_st(input string name, input logic [2:0] cnt, input logic fl, input logic af,
                        input logic em, input logic ae, input logic ov, input logic un);
    chk(name, {23'd0, count_o, full_o, almost_full_o, empty_o, almost_empty_o, overflow_o, underflow_o},
        {23'd0, cnt, fl, af, em, ae, ov, un});
  endtask

  task automatic step(input logic p, input logic [7:0] d, input logic q,
                      input logic f = 1'b0, input logic c = 1'b0);
    push_i = p; data_i = d; pop_i = q; flush_i = f; clr_err_i = c;
    @(posedge clk_i);
    #1;
  endtask

  // Scoreboard monitor: every accepted pop must present the next expected word.
  always @(negedge clk_i) begin
    if (rstn_i && pop_i && !flush_i && !empty_o) begin
      if (exp_q.size() == 0) begin
        chk("pop_unexpected", {24'd0, data_o}, 32'hFFFF_FFFF);
      end else begin
        chk("pop_data", {24'd0, data_o}, {24'd0, exp_q.pop_front()});
      end
    end
  end

  initial begin
    #1 rstn_i = 1'b0;
    repeat (2) @(posedge clk_i);
    #1;
    chk_st("reset_status", 3'd0, 0, 0, 1, 1, 0, 0);
    chk("reset_data", {24'd0, data_o}, 32'h0);
    @(negedge clk_i);
    rstn_i = 1'b1;
    step(0, 8'h00, 0);
    chk_st("idle_status", 3'd0, 0, 0, 1, 1, 0, 0);
    chk("idle_data", {24'd0, data_o}, 32'h0);

    // Fill
    exp_q.push_back(8'h11); step(1, 8'h11, 0);
    chk_st("fill1", 3'd1, 0, 0, 0, 1, 0, 0);
    chk("fill1_data", {24'd0, data_o}, 32'h11);
    exp_q.push_back(8'h22); step(1, 8'h22, 0);
    chk_st("fill2", 3'd2, 0, 0, 0, 0, 0, 0);
    exp_q.push_back(8'h33); step(1, 8'h33, 0);
    chk_st("fill3", 3'd3, 0, 1, 0, 0, 0, 0);
    exp_q.push_back(8'h44); step(1, 8'h44, 0);
    chk_st("fill4", 3'd4, 1, 1, 0, 0, 0, 0);
    chk("fill4_head", {24'd0, data_o}, 32'h11);

    step(1, 8'h99, 0);
    chk_st("overflow", 3'd4, 1, 1, 0, 0, 1, 0);

    // Push while full with simultaneous pop
    exp_q.push_back(8'h55); step(1, 8'h55, 1);
    chk_st("full_pushpop", 3'd4, 1, 1, 0, 0, 1, 0);
    chk("full_pushpop_head", {24'd0, data_o}, 32'h22);

    step(0, 8'h00, 1);
    chk("drain1_head", {24'd0, data_o}, 32'h33);
    step(0, 8'h00, 1);
    step(0, 8'h00, 1);
    chk_st("drain3", 3'd1, 0, 0, 0, 1, 1, 0);
    step(0, 8'h00, 1);
    chk_st("drained", 3'd0, 0, 0, 1, 1, 1, 0);
    chk("drained_data", {24'd0, data_o}, 32'h0);

    // Empty with push and pop together
    exp_q.push_back(8'hAA); step(1, 8'hAA, 1);
    chk_st("empty_pushpop", 3'd1, 0, 0, 0, 1, 1, 1);
    chk("empty_pushpop_data", {24'd0, data_o}, 32'hAA);
    step(0, 8'h00, 0, 0, 1);
    chk_st("clr_err", 3'd1, 0, 0, 0, 1, 0, 0);
    step(0, 8'h00, 1);
    chk_st("drain_aa", 3'd0, 0, 0, 1, 1, 0, 0);

    // Set beats clear in the same cycle
    step(0, 8'h00, 1, 0, 1);
    chk_st("set_over_clr", 3'd0, 0, 0, 1, 1, 0, 1);
    step(0, 8'h00, 0, 0, 1);
    chk_st("clr_after", 3'd0, 0, 0, 1, 1, 0, 0);

    // Wrap-around stream with one-cycle push lead
    exp_q.push_back(8'd0); step(1, 8'd0, 0);
    for (int i = 1; i < 10; i++) begin
      exp_q.push_back(8'(i));
      step(1, 8'(i), 1);
      chk("wrap_count", {29'd0, count_o}, 32'd1);
    end
    step(0, 8'h00, 1);
    chk_st("wrap_done", 3'd0, 0, 0, 1, 1, 0, 0);

    // Flush with push held high
    step(1, 8'h01, 0);
    step(1, 8'h02, 0);
    step(1, 8'h03, 0);
    chk_st("pre_flush", 3'd3, 0, 1, 0, 0, 0, 0);
    step(1, 8'h77, 0, 1, 0);
    chk_st("flush", 3'd0, 0, 0, 1, 1, 0, 0);
    chk("flush_data", {24'd0, data_o}, 32'h0);
    exp_q.push_back(8'h5A); step(1, 8'h5A, 0);
    chk("post_flush_head", {24'd0, data_o}, 32'h5A);
    step(0, 8'h00, 1);

    // Async reset mid-stream
    step(0, 8'h00, 1);
    step(1, 8'h66, 0);
    step(1, 8'h67, 0);
    chk_st("pre_reset", 3'd2, 0, 0, 0, 0, 0, 1);
    push_i = 1'b0;
    #2 rstn_i = 1'b0;
    #1;
    chk_st("async_reset", 3'd0, 0, 0, 1, 1, 0, 0);
    chk("async_reset_data", {24'd0, data_o}, 32'h0);
    @(negedge clk_i);
    rstn_i = 1'b1;
    step(0, 8'h00, 0);
    chk_st("after_reset", 3'd0, 0, 0, 1, 1, 0, 0);

    chk("scoreboard_left", exp_q.size(), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/fifo_param.md
Name: fifo_param

Overview:
- Parametrised synchronous FIFO; successor to the team's 4-bit, 16-entry FIFO.
- Data width and depth are independent parameters.
- Adds occupancy count, programmable almost-full/almost-empty flags, synchronous flush, push-while-full when a pop occurs in the same cycle, and sticky overflow/underflow error flags.
- Used as the generic buffering element between interconnect stages; first-word-fall-through read side.

Parameters:
- DATA_WIDTH, 8, width of each stored word (>=1).
- DEPTH, 16, number of entries; power of two, >=2.
- AF_THRESH, DEPTH-2, almost_full_o asserts when count >= AF_THRESH; range 1..DEPTH.
- AE_THRESH, 2, almost_empty_o asserts when count <= AE_THRESH; range 0..DEPTH-1.

Ports:
- clk_i  in  1  clock, rising edge.
- rstn_i  in  1  reset, asynchronous, active-low.
- flush_i  in  1  synchronous flush; empties the FIFO.
- clr_err_i  in  1  synchronous clear of the sticky error flags.
- data_i  in  DATA_WIDTH  write data.
- push_i  in  1  write request.
- full_o  out  1  count == DEPTH.
- almost_full_o  out  1  count >= AF_THRESH.
- data_o  out  DATA_WIDTH  head word (FWFT); '0 when empty.
- pop_i  in  1  read request / acknowledge of the head word.
- empty_o  out  1  count == 0.
- almost_empty_o  out  1  count <= AE_THRESH.
- count_o  out  $clog2(DEPTH)+1  current occupancy, 0..DEPTH.
- overflow_o  out  1  sticky: a push was dropped.
- underflow_o  out  1  sticky: a pop was dropped.

Behaviour:
- Pointers:
  - wptr and rptr are $clog2(DEPTH)+1 bits. The MSB is the wrap bit and the low bits index storage.
  - count = wptr - rptr, modulo 2^($clog2(DEPTH)+1).
- Status outputs:
  - All status outputs are combinational functions of the registered pointers/flags only. There is no combinational path from push_i or pop_i to any output.
- Reset (rstn_i low, async):
  - wptr = rptr = 0, overflow_o = underflow_o = 0.
  - Outputs: empty_o = 1, full_o = 0, count_o = 0, data_o = '0.
  - almost_empty_o = 1; almost_full_o = 0 (given AF_THRESH >= 1).
  - Storage array is not reset.
- Accept rules (evaluated each cycle, flush_i low):
  - pop_acc = pop_i & ~empty_o.
  - push_acc = push_i & (~full_o | pop_i).
    - When full, a push is accepted only if a pop is accepted the same cycle; count stays at DEPTH.
  - When empty with push and pop both high, the push is accepted and the pop is dropped (counts as underflow).
- Latency:
  - A word pushed in cycle N appears on data_o in cycle N+1 if the FIFO was empty.
  - data_o always shows mem[rptr] while non-empty. A pop advances rptr at the clock edge, and the next word is visible the following cycle.
- Pointer update:
  - wptr += push_acc; rptr += pop_acc. Wrap is natural binary rollover.
  - Storage write mem[wptr[low]] <= data_i on push_acc.
- Flush (flush_i high):
  - Next edge sets wptr = rptr = 0. Push/pop in that cycle are ignored and do not set error flags.
  - Storage content is left unchanged.
  - Error flags are unaffected unless clr_err_i is also high.
- Error flags:
  - overflow_o sets on push_i & full_o & ~pop_i.
  - underflow_o sets on pop_i & empty_o.
  - clr_err_i clears both. If a set condition and clr_err_i occur in the same cycle, set wins.
- Threshold comparisons are unsigned on count_o.

Decomposition:
- Shared package fifo_pkg holds:
  - function ptr_w(depth) returning $clog2(depth)+1;
  - typedef fifo_status_t (packed: full, almost_full, empty, almost_empty, overflow, underflow) for status aggregation in callers.
- Sub-module fifo_ram #(DATA_WIDTH, DEPTH):
  - simple dual-port array with a synchronous write port and an asynchronous read port;
  - not reset.
- fifo_param owns the pointers, flags and data_o gating.

Test Plan:
- Reset then idle -> empty_o=1, almost_empty_o=1, count_o=0, data_o=0, full_o=0, error flags=0.
- DATA_WIDTH=8, DEPTH=4, AF_THRESH=3, AE_THRESH=1:
  - push 0x11, 0x22, 0x33, 0x44 on consecutive cycles -> count_o 1,2,3,4; almost_full_o from count 3; full_o at 4; data_o=0x11 the cycle after the first push.
  - Then a fifth push alone -> dropped, overflow_o=1, count_o=4.
- Full FIFO, push 0x55 with pop in the same cycle -> count_o stays 4; data_o becomes 0x22. Subsequent pops yield 0x22, 0x33, 0x44, 0x55, then empty.
- Empty FIFO, push 0xAA and pop in the same cycle -> push accepted, underflow_o=1, count_o=1, data_o=0xAA. Then clr_err_i -> both error flags 0.
- Wrap-around:
  - 10 push/pop pairs through DEPTH=4 with data 0..9 -> output order 0..9; count_o never exceeds 2 with a one-cycle push lead.
- Fill to 3 entries, assert flush_i with push_i high -> next cycle count_o=0, empty_o=1, no overflow. Also assert rstn_i low mid-stream -> all outputs return to reset values immediately (async).
